axi_lite_reg_slice: RTL
=======================

Name: axi_lite_reg_slice

Overview:
- Full-throughput register slice for an AXI-lite link.
- Sits between the AXI-to-lite bridge and the AXI-lite BRAM controller. Breaks every combinational valid/ready/payload path on all five channels (AW, W, B, AR, R).
- Preserves ordering and allows one beat per cycle per channel. Purely a timing stage: no protocol conversion.

Parameters:
- ADDR_WIDTH, 32, width of aw_addr/ar_addr; must match both interfaces.
- DATA_WIDTH, 32, width of w_data/r_data; w_strb is DATA_WIDTH/8.
- SLICE_MASK, 5'b11111, per-channel enable, bit order {R,AR,B,W,AW}.
  - 1 = registered skid buffer.
  - 0 = combinational pass-through wires.

Ports:
- clk  input  1  clock; same net as both interfaces' clk.
- rstn  input  1  asynchronous active-low reset; same net as both interfaces' rstn.
- master  axi_lite_channel.slave  -  upstream side, driven by the bridge. Channels: aw_addr/aw_prot/aw_valid/aw_ready, w_data/w_strb/w_valid/w_ready, b_resp/b_valid/b_ready, ar_addr/ar_prot/ar_valid/ar_ready, r_data/r_resp/r_valid/r_ready.
- slave  axi_lite_channel.master  -  downstream side, drives the BRAM controller.

Behaviour:
- Each enabled channel is one skid buffer: main register plus one skid register. Forward direction: AW, W, AR go master→slave; B, R go slave→master.
- Reset (rstn low, asynchronous):
  - out_valid=0; in_ready=1 (registered); main and skid valid flags=0.
  - Payload registers need not be reset.
  - Any beat in flight is discarded. The block is idle on the first clk edge after rstn rises.
- Latency and throughput:
  - A beat accepted at edge N (in_valid & in_ready) appears on out_valid after edge N.
  - Sustained 1 beat/cycle when out_ready is held high.
- State per buffer: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
- Transitions:
  - EMPTY + in handshake → ONE.
  - ONE + in handshake + out handshake → ONE; main loads the new beat.
  - ONE + in handshake, no out handshake → FULL; new beat goes to skid; in_ready=0 next cycle.
  - ONE + out handshake only → EMPTY.
  - FULL + out handshake → ONE; skid moves to main; in_ready=1 next cycle.
  - FULL never accepts input.
- in_ready is a function of registered state only (high unless FULL). out_valid and out payload come directly from main registers. No combinational path from out_ready to in_ready.
- AXI rules:
  - out_valid, once asserted, stays high with stable payload until out_ready.
  - Upstream valid/payload stability is not checked at runtime.
- Channels are independent:
  - AW and W may pass in any relative order; the slice neither pairs nor reorders them.
  - B/R order equals the order accepted from the slave side.
- Masked channel (SLICE_MASK bit 0): out=in and in_ready=out_ready combinationally; zero latency; reset has no effect on it.
- Widths:
  - AW/AR payload = ADDR_WIDTH+3.
  - W payload = DATA_WIDTH+DATA_WIDTH/8.
  - B payload = 2.
  - R payload = DATA_WIDTH+2.

Optional Feature:
- Macro AXI_LITE_REG_SLICE_ASSERT_EN.
- Defined: concurrent assertions on both sides, disabled while rstn low:
  - valid held until ready, with stable payload;
  - no out_valid in the cycle after reset release;
  - per-channel beat-count conservation (accepted in − delivered out ∈ {0,1,2}).
- Undefined: no assertion code compiled; RTL behaviour identical.

Decomposition:
- Package axi_lite_reg_slice_pkg:
  - SLICE_AW..SLICE_R bit-index constants for SLICE_MASK;
  - resp encoding typedef (OKAY=2'b00, SLVERR=2'b10);
  - payload-width helper functions.
- Sub-module axi_lite_skid_buf (parameter WIDTH), instantiated five times with packed payloads.

Test Plan:
- Back-to-back reads, slave-side r_ready=1: 8 ARs at addr 0x0,0x4..0x1C on consecutive cycles → 8 ARs on slave side, each 1 cycle later, same order. ar_ready never drops.
- Stall: slave aw_ready=0 for 5 cycles while master sends AW 0x100,0x104,0x108 → first two held, master aw_ready=0 from the cycle after the second accept. 0x108 waits and is delivered third once ready returns.
- Write path: W data 0xDEADBEEF strb 4'b1111 with AW 0x40 → slave sees both unchanged. B resp 2'b00 returns to master 1 cycle after the slave's b_valid.
- Reset mid-operation: rstn low while FULL on R with beats 0x11,0x22 → r_valid=0 and r_ready=1 immediately. After release, no stale beat appears.
- SLICE_MASK=5'b00000: random traffic → zero-cycle latency, identical to wires.
- Random valid/ready toggling (50%) for 10k cycles on all channels with assertions enabled → no assertion failures, scoreboard match.

Source files
------------

// File: rtl/axi_lite_reg_slice_pkg.sv
// Shared constants, types and payload-width helpers for the AXI-lite register slice.
package axi_lite_reg_slice_pkg;

    // Bit positions inside SLICE_MASK, order {R,AR,B,W,AW}
    localparam int unsigned SLICE_AW   = 0;
    localparam int unsigned SLICE_W    = 1;
    localparam int unsigned SLICE_B    = 2;
    localparam int unsigned SLICE_AR   = 3;
    localparam int unsigned SLICE_R    = 4;
    localparam int unsigned NUM_SLICES = 5;

    localparam int unsigned PROT_WIDTH = 3;
    localparam int unsigned RESP_WIDTH = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Occupancy of one skid buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned addr_payload_width(input int unsigned addr_width);
        return addr_width + PROT_WIDTH;
    endfunction

    function automatic int unsigned w_payload_width(input int unsigned data_width);
        return data_width + strb_width(data_width);
    endfunction

    function automatic int unsigned b_payload_width();
        return RESP_WIDTH;
    endfunction

    function automatic int unsigned r_payload_width(input int unsigned data_width);
        return data_width + RESP_WIDTH;
    endfunction

endpackage

// File: rtl/axi_lite_skid_buf.sv
// One-channel skid buffer (main + skid register) or plain wires when ENABLE=0.
// Optional checks compiled with AXI_LITE_REG_SLICE_ASSERT_EN.
module axi_lite_skid_buf
    import axi_lite_reg_slice_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (ENABLE) begin : g_reg
        buf_state_e       state_q, state_d;
        logic             in_ready_q, in_ready_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             in_hs, out_hs;

        // in_ready is registered, so out_ready never reaches it combinationally
        assign in_hs  = in_valid & in_ready_q;
        assign out_hs = (state_q != BUF_EMPTY) & out_ready;

        // Occupancy and registered ready; in-flight beats dropped on reset
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q    <= BUF_EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                in_ready_q <= in_ready_d;
            end
        end

        // Payload registers carry no reset; validity lives in state_q
        always_ff @(posedge clk) begin
            main_q <= main_d;
            skid_q <= skid_d;
        end

        // Next occupancy and payload steering
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                BUF_EMPTY: begin
                    if (in_hs) begin
                        state_d = BUF_ONE;
                        main_d  = in_data;
                    end
                end
                BUF_ONE: begin
                    if (in_hs && out_hs) begin
                        main_d = in_data;
                    end else if (in_hs) begin
                        state_d = BUF_FULL;
                        skid_d  = in_data;
                    end else if (out_hs) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_hs) begin
                        state_d = BUF_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
            in_ready_d = (state_d != BUF_FULL);
        end

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != BUF_EMPTY);
        assign out_data  = main_q;

`ifdef AXI_LITE_REG_SLICE_ASSERT_EN
        logic [2:0] occ_q;

        // Beats accepted minus beats delivered
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                occ_q <= 3'd0;
            end else begin
                occ_q <= occ_q + 3'(in_hs) - 3'(out_hs);
            end
        end

        a_out_hold: assert property (@(posedge clk) disable iff (!rstn)
            (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
        a_in_hold: assert property (@(posedge clk) disable iff (!rstn)
            (in_valid && !in_ready) |=> (in_valid && $stable(in_data)));
        a_rst_idle: assert property (@(posedge clk) $rose(rstn) |-> !out_valid);
        a_conserve: assert property (@(posedge clk) disable iff (!rstn)
            occ_q <= 3'd2);
`endif
    end else begin : g_wire
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rstn;
        assign in_ready       = out_ready;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end

endmodule

// File: rtl/axi_lite_reg_slice.sv
// AXI-lite register slice: one skid buffer per channel, selectable by SLICE_MASK.
// Optional checks compiled with AXI_LITE_REG_SLICE_ASSERT_EN.
module axi_lite_reg_slice
    import axi_lite_reg_slice_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [NUM_SLICES-1:0] SLICE_MASK = 5'b11111
) (
    input  logic                    clk,
    input  logic                    rstn,
    // upstream (bridge) side
    input  logic [ADDR_WIDTH-1:0]   m_aw_addr,
    input  logic [2:0]              m_aw_prot,
    input  logic                    m_aw_valid,
    output logic                    m_aw_ready,
    input  logic [DATA_WIDTH-1:0]   m_w_data,
    input  logic [DATA_WIDTH/8-1:0] m_w_strb,
    input  logic                    m_w_valid,
    output logic                    m_w_ready,
    output logic [1:0]              m_b_resp,
    output logic                    m_b_valid,
    input  logic                    m_b_ready,
    input  logic [ADDR_WIDTH-1:0]   m_ar_addr,
    input  logic [2:0]              m_ar_prot,
    input  logic                    m_ar_valid,
    output logic                    m_ar_ready,
    output logic [DATA_WIDTH-1:0]   m_r_data,
    output logic [1:0]              m_r_resp,
    output logic                    m_r_valid,
    input  logic                    m_r_ready,
    // downstream (BRAM controller) side
    output logic [ADDR_WIDTH-1:0]   s_aw_addr,
    output logic [2:0]              s_aw_prot,
    output logic                    s_aw_valid,
    input  logic                    s_aw_ready,
    output logic [DATA_WIDTH-1:0]   s_w_data,
    output logic [DATA_WIDTH/8-1:0] s_w_strb,
    output logic                    s_w_valid,
    input  logic                    s_w_ready,
    input  logic [1:0]              s_b_resp,
    input  logic                    s_b_valid,
    output logic                    s_b_ready,
    output logic [ADDR_WIDTH-1:0]   s_ar_addr,
    output logic [2:0]              s_ar_prot,
    output logic                    s_ar_valid,
    input  logic                    s_ar_ready,
    input  logic [DATA_WIDTH-1:0]   s_r_data,
    input  logic [1:0]              s_r_resp,
    input  logic                    s_r_valid,
    output logic                    s_r_ready
);

    localparam int unsigned AX_PW = addr_payload_width(ADDR_WIDTH);
    localparam int unsigned W_PW  = w_payload_width(DATA_WIDTH);
    localparam int unsigned B_PW  = b_payload_width();
    localparam int unsigned R_PW  = r_payload_width(DATA_WIDTH);

    logic [AX_PW-1:0] aw_out;
    logic [W_PW-1:0]  w_out;
    logic [AX_PW-1:0] ar_out;
    logic [R_PW-1:0]  r_out;

    assign {s_aw_addr, s_aw_prot} = aw_out;
    assign {s_w_data, s_w_strb}   = w_out;
    assign {s_ar_addr, s_ar_prot} = ar_out;
    assign {m_r_data, m_r_resp}   = r_out;

    // Write address, master -> slave
    axi_lite_skid_buf #(.WIDTH(AX_PW), .ENABLE(SLICE_MASK[SLICE_AW])) u_aw (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (m_aw_valid),
        .in_ready  (m_aw_ready),
        .in_data   ({m_aw_addr, m_aw_prot}),
        .out_valid (s_aw_valid),
        .out_ready (s_aw_ready),
        .out_data  (aw_out)
    );

    // Write data, master -> slave
    axi_lite_skid_buf #(.WIDTH(W_PW), .ENABLE(SLICE_MASK[SLICE_W])) u_w (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (m_w_valid),
        .in_ready  (m_w_ready),
        .in_data   ({m_w_data, m_w_strb}),
        .out_valid (s_w_valid),
        .out_ready (s_w_ready),
        .out_data  (w_out)
    );

    // Write response, slave -> master
    axi_lite_skid_buf #(.WIDTH(B_PW), .ENABLE(SLICE_MASK[SLICE_B])) u_b (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_b_valid),
        .in_ready  (s_b_ready),
        .in_data   (s_b_resp),
        .out_valid (m_b_valid),
        .out_ready (m_b_ready),
        .out_data  (m_b_resp)
    );

    // Read address, master -> slave
    axi_lite_skid_buf #(.WIDTH(AX_PW), .ENABLE(SLICE_MASK[SLICE_AR])) u_ar (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (m_ar_valid),
        .in_ready  (m_ar_ready),
        .in_data   ({m_ar_addr, m_ar_prot}),
        .out_valid (s_ar_valid),
        .out_ready (s_ar_ready),
        .out_data  (ar_out)
    );

    // Read data, slave -> master
    axi_lite_skid_buf #(.WIDTH(R_PW), .ENABLE(SLICE_MASK[SLICE_R])) u_r (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (s_r_valid),
        .in_ready  (s_r_ready),
        .in_data   ({s_r_data, s_r_resp}),
        .out_valid (m_r_valid),
        .out_ready (m_r_ready),
        .out_data  (r_out)
    );

endmodule
